poly_addsub_ctrl: RTL

- Sequencer for coefficient-wise polynomial addition or subtraction mod Q (Q = 12587009, 24-bit coefficients) over N-coefficient polynomials held in the NTT coefficient RAMs.
- On start, sweeps addresses 0..N-1 and reads operand banks A and B in lockstep.
- Streams each coefficient pair through a one-cycle modular add/sub stage and writes results to bank C at the same address.
- Sits beside the NTT butterfly controller; used for the polynomial add/sub steps of NTRU key generation and encapsulation.

---
 rtl/poly_addsub_ctrl_pkg.sv | 29 ++
 rtl/poly_addsub_ctrl_if.sv | 46 ++++
 rtl/poly_addsub_ctrl_mod_addsub_pipe.sv | 95 +++++++++
 rtl/poly_addsub_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/poly_addsub_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : poly_addsub_ctrl_pkg                                            |
// | Purpose  : Shared constants and sequencer state encoding for the           |
// |            coefficient-wise polynomial add/sub controller. The top-level   |
// |            NTRU sequencer reuses the state type and modulus constants.     |
// | Contents : Q_MOD, COEF_W, N_DEF, ADDR_W_DEF, state_e                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package poly_addsub_ctrl_pkg;

  // Modulus and coefficient width used across the NTRU datapath.
  localparam int unsigned Q_MOD      = 32'd12587009;
  localparam int unsigned COEF_W     = 24;

  // Default polynomial length and matching address width.
  localparam int unsigned N_DEF      = 1024;
  localparam int unsigned ADDR_W_DEF = 10;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : poly_addsub_ctrl_pkg
`default_nettype wire

// File: rtl/poly_addsub_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : poly_addsub_ctrl_if                                             |
// | Purpose  : Command, stall and coefficient-RAM bus of the polynomial        |
// |            add/sub sequencer.                                              |
// | Ports    : start/op/stall       - command and arbiter inputs to the ctrl   |
// |            busy/done            - status from the ctrl                     |
// |            rd_en/rd_addr        - shared read port of banks A and B        |
// |            rd_data_a/rd_data_b  - bank read data, one cycle after rd_en    |
// |            wr_en/wr_addr/wr_data- write port of bank C                     |
// | Modports : slave  - the sequencer                                          |
// |            master - the environment (host, arbiter and RAM banks)          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface poly_addsub_ctrl_if
  import poly_addsub_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned W      = COEF_W
);

  logic              start;
  logic              op;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [W-1:0]      rd_data_a;
  logic [W-1:0]      rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      wr_data;

  modport slave (
    input  start, op, stall, rd_data_a, rd_data_b,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, op, stall, rd_data_a, rd_data_b,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface : poly_addsub_ctrl_if
`default_nettype wire

// File: rtl/poly_addsub_ctrl_mod_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_addsub_pipe                                                 |
// | Purpose  : Two-stage modular add/sub pipeline with valid tracking and a    |
// |            global hold enable.                                             |
// |            Stage 1 : the coefficient RAMs present a/b; this module keeps   |
// |                      the matching valid bit, op and address tag.           |
// |            Stage 2 : registered 25-bit s = a + b  or  a + (Q - b).         |
// |            Output  : s reduced into [0, Q-1] by one conditional subtract.  |
// | Ports    : clk, rst_n         - clock, async active-low reset              |
// |            en_i               - advance enable (low = hold everything)     |
// |            valid_i/op_i/tag_i - read issued this cycle, its op and address |
// |            a_i, b_i           - RAM data for the stage-1 entry             |
// |            s1_valid_o         - stage-1 occupancy                          |
// |            valid_o/tag_o      - stage-2 occupancy and its address          |
// |            result_o           - reduced result of the stage-2 entry        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mod_addsub_pipe
  import poly_addsub_ctrl_pkg::*;
#(
  parameter int unsigned W     = COEF_W,
  parameter int unsigned Q     = Q_MOD,
  parameter int unsigned TAG_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             s1_valid_o,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [W-1:0]     result_o
);

  localparam logic [W:0] C_Q = (W+1)'(Q);

  // Stage 1: the data register itself lives in the RAM output; only the
  // sideband travelling with it is held here.
  logic             v1_q;
  logic             op1_q;
  logic [TAG_W-1:0] tag1_q;

  // Stage 2: unreduced sum plus its address.
  logic             v2_q;
  logic [TAG_W-1:0] tag2_q;
  logic [W:0]       s_q;

  logic [W:0] w_b_ext;
  logic [W:0] w_neg_b;
  logic [W:0] w_s_d;
  logic       w_ge_q;

  // Subtraction is folded into an addition of the additive inverse. b == 0
  // must map to 0 rather than Q so that s stays below 2Q.
  assign w_b_ext = {1'b0, b_i};
  assign w_neg_b = (b_i == '0) ? '0 : (C_Q - w_b_ext);
  assign w_s_d   = {1'b0, a_i} + (op1_q ? w_neg_b : w_b_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      op1_q  <= 1'b0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      tag2_q <= '0;
      s_q    <= '0;
    end else if (en_i) begin
      v1_q <= valid_i;
      if (valid_i) begin
        op1_q  <= op_i;
        tag1_q <= tag_i;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        s_q    <= w_s_d;
        tag2_q <= tag1_q;
      end
    end
  end

  // s < 2Q, so a single conditional subtract lands in [0, Q-1] and the
  // result always fits in W bits.
  assign w_ge_q     = (s_q >= C_Q);
  assign result_o   = W'(s_q - (w_ge_q ? C_Q : '0));
  assign s1_valid_o = v1_q;
  assign valid_o    = v2_q;
  assign tag_o      = tag2_q;

endmodule : mod_addsub_pipe
`default_nettype wire

// File: rtl/poly_addsub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : poly_addsub_ctrl                                                |
// | Purpose  : Sequencer for C = A + B mod Q or C = A - B mod Q over N-entry   |
// |            coefficient banks. Sweeps addresses 0..N-1 reading A and B in   |
// |            lockstep, streams pairs through mod_addsub_pipe and writes each |
// |            result to bank C at the same address.                           |
// | Ports    : clk   - system clock                                            |
// |            rst_n - asynchronous active-low reset                           |
// |            bus   - poly_addsub_ctrl_if.slave (command, status, RAM ports)  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module poly_addsub_ctrl
  import poly_addsub_ctrl_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned W      = COEF_W,
  parameter int unsigned Q      = Q_MOD
) (
  input  logic                clk,
  input  logic                rst_n,
  poly_addsub_ctrl_if.slave   bus
);

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              op_q, op_d;

  logic              w_adv;
  logic              w_rd_en;
  logic              w_s1_valid;
  logic              w_s2_valid;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [W-1:0]      w_wr_data;

  // The arbiter stall freezes the whole datapath; it only matters while
  // reads or writes are in flight (RUN, DRAIN).
  assign w_adv = !bus.stall;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and read issue
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    w_rd_en = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          op_d    = bus.op;
          state_d = RUN;
        end
      end

      RUN: begin
        if (w_adv) begin
          w_rd_en = 1'b1;
          // Wraps back to 0 after N-1, leaving the counter ready for the
          // next run.
          cnt_d   = cnt_q + ADDR_W'(1);
          if (cnt_q == C_LAST) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Leave once both valid bits will be clear after this edge: with
        // stage 1 empty and the pipe advancing, the stage-2 entry is
        // written in this very cycle.
        if ((w_adv && !w_s1_valid) || (!w_s1_valid && !w_s2_valid)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  mod_addsub_pipe #(
    .W     (W),
    .Q     (Q),
    .TAG_W (ADDR_W)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (w_adv),
    .valid_i    (w_rd_en),
    .op_i       (op_q),
    .tag_i      (cnt_q),
    .a_i        (bus.rd_data_a),
    .b_i        (bus.rd_data_b),
    .s1_valid_o (w_s1_valid),
    .valid_o    (w_s2_valid),
    .tag_o      (w_wr_addr),
    .result_o   (w_wr_data)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = cnt_q;
  assign bus.wr_en   = w_s2_valid && w_adv;
  assign bus.wr_addr = w_wr_addr;
  assign bus.wr_data = w_wr_data;

endmodule : poly_addsub_ctrl
`default_nettype wire
